// File: rtl/snake_collision_checker.sv
// Per-step snake checker: wall and apple hit on the head, then a one-segment-per-clock
// body scan for self collision. Exposes the FSM state on o_dbg_state.
module snake_collision_checker #(
    parameter int MaxSize         = 128,
    parameter int InitSize        = 8,
    parameter int BorderThickness = 10,
    parameter int AppleWidth      = 10,
    parameter int AppleHeight     = 10,
    parameter int ScreenW         = 240,
    parameter int ScreenH         = 320
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   moveTick,
    input  logic [8*MaxSize-1:0]   snakeLocX,
    input  logic [9*MaxSize-1:0]   snakeLocY,
    input  logic [7:0]             appleLocX,
    input  logic [8:0]             appleLocY,
    output logic                   appleEaten,
    output logic [7:0]             size,
    output logic                   gameOver,
    output logic                   busy,
    output logic [2:0]             o_dbg_state
);

    typedef enum logic [2:0] {IDLE, LATCH, APPLE, SCAN, DONE} state_t;

    localparam logic [7:0] WALL_X_LO = 8'(BorderThickness);
    localparam logic [7:0] WALL_X_HI = 8'(ScreenW - BorderThickness);
    localparam logic [8:0] WALL_Y_LO = 9'(BorderThickness);
    localparam logic [8:0] WALL_Y_HI = 9'(ScreenH - BorderThickness);
    localparam logic [8:0] APPLE_W   = 9'(AppleWidth);
    localparam logic [9:0] APPLE_H   = 10'(AppleHeight);
    localparam logic [7:0] SIZE_MAX  = 8'(MaxSize);
    localparam logic [7:0] SIZE_INIT = 8'(InitSize);

    state_t     r_state;
    logic [7:0] r_head_x;
    logic [8:0] r_head_y;
    logic [7:0] r_apple_x;
    logic [8:0] r_apple_y;
    logic [7:0] r_lat_size;
    logic [7:0] r_idx;
    logic       r_apple_eaten;
    logic [7:0] r_size;
    logic       r_game_over;
    logic       r_busy;

    logic       w_wall_hit;
    logic       w_apple_hit;
    logic [7:0] w_seg_x;
    logic [8:0] w_seg_y;
    logic       w_seg_match;

    assign w_wall_hit = (r_head_x < WALL_X_LO) || (r_head_x >= WALL_X_HI) ||
                        (r_head_y < WALL_Y_LO) || (r_head_y >= WALL_Y_HI);

    // Upper bounds are formed one bit wider so an apple near the edge never wraps.
    assign w_apple_hit = (r_head_x >= r_apple_x) &&
                         ({1'b0, r_head_x} < ({1'b0, r_apple_x} + APPLE_W)) &&
                         (r_head_y >= r_apple_y) &&
                         ({1'b0, r_head_y} < ({1'b0, r_apple_y} + APPLE_H));

    always_comb begin
        w_seg_x     = snakeLocX[8*int'(r_idx) +: 8];
        w_seg_y     = snakeLocY[9*int'(r_idx) +: 9];
        w_seg_match = (w_seg_x == r_head_x) && (w_seg_y == r_head_y);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_head_x      <= '0;
            r_head_y      <= '0;
            r_apple_x     <= '0;
            r_apple_y     <= '0;
            r_lat_size    <= '0;
            r_idx         <= '0;
            r_apple_eaten <= 1'b0;
            r_size        <= SIZE_INIT;
            r_game_over   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_apple_eaten <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (moveTick && !r_game_over) begin
                        r_state <= LATCH;
                        r_busy  <= 1'b1;
                    end
                end
                LATCH: begin
                    r_head_x   <= snakeLocX[7:0];
                    r_head_y   <= snakeLocY[8:0];
                    r_apple_x  <= appleLocX;
                    r_apple_y  <= appleLocY;
                    r_lat_size <= r_size;
                    r_idx      <= 8'd1;
                    r_state    <= APPLE;
                end
                APPLE: begin
                    if (w_wall_hit) begin
                        r_game_over <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        if (w_apple_hit) begin
                            r_apple_eaten <= 1'b1;
                            if (r_size != SIZE_MAX) begin
                                r_size <= r_size + 8'd1;
                            end
                        end
                        r_state <= (r_lat_size > 8'd1) ? SCAN : DONE;
                    end
                end
                SCAN: begin
                    // The scan is bounded by the size latched at the step start.
                    if (w_seg_match) begin
                        r_game_over <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_idx == r_lat_size - 8'd1) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 8'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign appleEaten  = r_apple_eaten;
    assign size        = r_size;
    assign gameOver    = r_game_over;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_snake_collision_checker.sv
// Bench for snake_collision_checker: step vectors from a table scored through an
// expected queue, plus sequences for sticky game over, saturation and reset mid-scan.
module tb_snake_collision_checker;

    localparam int MAX = 128;

    logic               clock = 1'b0;
    logic               reset;
    logic               moveTick;
    logic [8*MAX-1:0]   snakeLocX;
    logic [9*MAX-1:0]   snakeLocY;
    logic [7:0]         appleLocX;
    logic [8:0]         appleLocY;
    logic               appleEaten;
    logic [7:0]         size;
    logic               gameOver;
    logic               busy;
    logic [2:0]         dbg_state;

    always #5 clock = ~clock;

    snake_collision_checker dut (
        .clock       (clock),
        .reset       (reset),
        .moveTick    (moveTick),
        .snakeLocX   (snakeLocX),
        .snakeLocY   (snakeLocY),
        .appleLocX   (appleLocX),
        .appleLocY   (appleLocY),
        .appleEaten  (appleEaten),
        .size        (size),
        .gameOver    (gameOver),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    typedef struct {
        bit         rst;
        logic [7:0] hx;
        logic [8:0] hy;
        logic [7:0] ax;
        logic [8:0] ay;
        int         seg;
        bit         extra;
        bit         eat;
        bit         go;
        int         lat;
    } vec_t;

    vec_t        vecs[18];
    logic [17:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_size  = 8;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset  = 1'b0;
        m_size = 8;
    endtask

    task automatic load_body(input logic [7:0] hx, input logic [8:0] hy, input int seg);
        for (int k = 0; k < MAX; k++) begin
            snakeLocX[8*k +: 8] = hx;
            snakeLocY[9*k +: 9] = hy + 9'(k);
        end
        if (seg > 0) snakeLocY[9*seg +: 9] = hy;
    endtask

    // Drives one step from a negedge and scores it when busy falls.
    task automatic run_step(input logic [7:0] hx, input logic [8:0] hy,
                            input logic [7:0] ax, input logic [8:0] ay,
                            input int seg, input bit extra,
                            input bit e_eat, input bit e_go, input int e_lat);
        int          eat_cnt = 0;
        int          eat_cyc = -1;
        int          lat     = -1;
        int          late    = 0;
        logic [17:0] exp;
        load_body(hx, hy, seg);
        appleLocX = ax;
        appleLocY = ay;
        if (e_eat && m_size < MAX) m_size++;
        exp_q.push_back({e_eat, e_go, 8'(m_size), 8'(e_lat)});
        moveTick = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if (c == 0) moveTick = 1'b0;
            if (extra && c == 3) moveTick = 1'b1;
            if (extra && c == 4) moveTick = 1'b0;
            if (appleEaten) begin
                eat_cnt++;
                eat_cyc = c;
            end
            if (c >= 1 && !busy) begin
                lat = c;
                break;
            end
        end
        exp = exp_q.pop_front();
        check("eat_count", eat_cnt, int'(exp[17]));
        if (exp[17]) check("eat_cycle", eat_cyc, 2);
        check("size", int'(size), int'(exp[15:8]));
        check("game_over", int'(gameOver), int'(exp[16]));
        check("latency", lat, int'(exp[7:0]));
        if (extra) begin
            repeat (3) begin
                @(negedge clock);
                late += int'(busy);
            end
            check("overlap_ignored", late, 0);
        end
    endtask

    initial begin
        int changed;
        reset     = 1'b1;
        moveTick  = 1'b0;
        snakeLocX = '0;
        snakeLocY = '0;
        appleLocX = '0;
        appleLocY = '0;

        //         rst  hx   hy   ax   ay  seg ext eat go lat
        vecs[0]  = '{1, 100, 150,   0,   0,  8, 0, 0, 0, 10};
        vecs[1]  = '{0, 100, 150,  95, 145, -1, 0, 1, 0, 10};
        vecs[2]  = '{0, 100, 150,  90, 145, -1, 0, 0, 0, 11};
        vecs[3]  = '{0, 100, 150,  91, 141, -1, 0, 1, 0, 11};
        vecs[4]  = '{0, 100, 150, 100, 150, -1, 0, 1, 0, 12};
        vecs[5]  = '{0, 100, 150, 101, 150, -1, 0, 0, 0, 13};
        vecs[6]  = '{0, 100, 150, 100, 140, -1, 0, 0, 0, 13};
        vecs[7]  = '{0, 100, 150,  95, 145, -1, 1, 1, 0, 13};
        vecs[8]  = '{0,  10,  10,   5,   5, -1, 0, 1, 0, 14};
        vecs[9]  = '{0, 229, 309,   0,   0, -1, 0, 0, 0, 15};
        vecs[10] = '{1,   9, 150,   0, 145, -1, 0, 0, 1, 3};
        vecs[11] = '{1, 230, 150,   0,   0, -1, 0, 0, 1, 3};
        vecs[12] = '{1, 100,   9,   0,   0, -1, 0, 0, 1, 3};
        vecs[13] = '{1, 100, 310,   0,   0, -1, 0, 0, 1, 3};
        vecs[14] = '{1,   5, 150,   0, 145, -1, 0, 0, 1, 3};
        vecs[15] = '{1, 100, 150,   0,   0,  5, 0, 0, 1, 8};
        vecs[16] = '{1, 100, 150,   0,   0,  1, 0, 0, 1, 4};
        vecs[17] = '{1, 100, 150,  95, 145,  7, 0, 1, 1, 10};

        do_reset();
        check("rst_size", int'(size), 8);
        check("rst_eaten", int'(appleEaten), 0);
        check("rst_game_over", int'(gameOver), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_state", int'(dbg_state), 0);
        changed = 0;
        repeat (100) begin
            @(negedge clock);
            if (size != 8'd8 || appleEaten || gameOver || busy) changed++;
        end
        check("idle_stable", changed, 0);

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rst) do_reset();
            run_step(vecs[i].hx, vecs[i].hy, vecs[i].ax, vecs[i].ay, vecs[i].seg,
                     vecs[i].extra, vecs[i].eat, vecs[i].go, vecs[i].lat);
        end

        // Game over is sticky: a new step must not start.
        changed = 0;
        load_body(8'd100, 9'd150, -1);
        appleLocX = 8'd95;
        appleLocY = 9'd145;
        moveTick  = 1'b1;
        @(negedge clock);
        moveTick = 1'b0;
        repeat (20) begin
            if (busy || appleEaten) changed++;
            @(negedge clock);
        end
        check("sticky_ignored", changed, 0);
        check("sticky_size", int'(size), 9);
        check("sticky_game_over", int'(gameOver), 1);

        // Grow to capacity, then one more hit must pulse but hold the size.
        do_reset();
        while (m_size < MAX) run_step(8'd100, 9'd150, 8'd95, 9'd145, -1, 1'b0, 1'b1, 1'b0, 3 + m_size - 1);
        run_step(8'd100, 9'd150, 8'd95, 9'd145, -1, 1'b0, 1'b1, 1'b0, 130);
        check("sat_size", int'(size), 128);

        // Reset landing in the middle of a scan.
        load_body(8'd100, 9'd150, -1);
        moveTick = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            moveTick = 1'b0;
        end
        check("midscan_state", int'(dbg_state), 3);
        check("midscan_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_size", int'(size), 8);
        check("abort_eaten", int'(appleEaten), 0);
        check("abort_game_over", int'(gameOver), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_state", int'(dbg_state), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
